watchdog_reset_gen: RTL and testbench
=====================================

WATCHDOG_RESET_GEN -- requirements
Module: WATCHDOG_RESET_GEN

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  TIMEOUT_CYC  50000000  cycles without a kick before firing (1 s at 50 MHz); legal range >= 2
  PULSE_CYC  5000000  width of the generated reset pulse in cycles (100 ms); legal range >= 1
  CNT_W  32  counter width; must hold max(TIMEOUT_CYC, PULSE_CYC)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  OSC_50  in  1  sole clock, 50 MHz, all logic on rising edge
  RESET_N  in  1  asynchronous active-low reset
  ENABLE  in  1  watchdog enable, synchronous to OSC_50
  KICK  in  1  service input, asynchronous; a rising edge counts as a kick
  CLR_FLAG  in  1  synchronous clear of TIMEOUT_FLAG
  WDT_RST_N  out  1  registered active-low reset request, intended to drive a button-style reset input of a reset-delay block
  TIMEOUT_FLAG  out  1  sticky, set on every fire
  STATE  out  2  current FSM state encoding
REQ-003 One clock domain only; asynchronous and active-low reset as fixed above.

Function
REQ-004 KICK SHALL pass a 2-flop synchronizer and a third history flop; kick_edge = sync2 AND NOT sync3.
REQ-005 FSM states SHALL be: IDLE=2'b00, RUN=2'b01, FIRE=2'b10; 2'b11 SHALL be unreachable and recover to IDLE on the next clock.
REQ-006 IDLE: CNT held at 0, WDT_RST_N=1; ENABLE=1 -> RUN with CNT=0 on the next edge.
REQ-007 RUN: kick_edge -> CNT<=0; else ENABLE=0 -> IDLE, CNT<=0; else CNT==TIMEOUT_CYC-1 -> FIRE, CNT<=0, WDT_RST_N<=0, TIMEOUT_FLAG<=1; else CNT<=CNT+1.
REQ-008 First WDT_RST_N low cycle SHALL be exactly TIMEOUT_CYC cycles after the last CNT clear, with no intervening kick.
REQ-009 Simultaneous kick_edge and terminal count in RUN: the kick SHALL win; no fire occurs.
REQ-010 FIRE: kicks ignored; ENABLE ignored; CNT increments; at CNT==PULSE_CYC-1: WDT_RST_N<=1, CNT<=0, next state RUN if ENABLE=1, else IDLE.
REQ-011 WDT_RST_N SHALL be low for exactly PULSE_CYC consecutive cycles per fire, glitch-free (driven directly by a flop).
REQ-012 TIMEOUT_FLAG SHALL stay set until a cycle with CLR_FLAG=1; set and clear in the same cycle -> set wins.
REQ-013 CNT SHALL never wrap; arithmetic is unsigned CNT_W bits; comparisons are equality against parameter-1.

Reset
REQ-014 While RESET_N=0: state=IDLE, CNT=0, WDT_RST_N=1, TIMEOUT_FLAG=0, synchronizer flops=0; all asynchronous.
REQ-015 RESET_N asserted mid-FIRE SHALL end the pulse immediately (WDT_RST_N=1 asynchronously).
REQ-016 Release of RESET_N SHALL take effect on the first OSC_50 rising edge after deassertion; a KICK held high at release SHALL NOT register as a kick until it goes low and then high again.

Verification (TIMEOUT_CYC=20, PULSE_CYC=5)
REQ-017 ENABLE=1, no kicks -> WDT_RST_N low 20 cycles after RUN entry, for exactly 5 cycles, then repeats every 25 cycles; TIMEOUT_FLAG=1 after the first fire.
REQ-018 Kick edge every 15 cycles -> WDT_RST_N stays 1 for 1000 cycles; TIMEOUT_FLAG stays 0.
REQ-019 kick_edge aligned with CNT==19 -> no fire; CNT=0 on the next cycle; kick during FIRE -> pulse still exactly 5 cycles.
REQ-020 ENABLE dropped at CNT=10 -> IDLE, CNT=0, no fire; ENABLE dropped mid-FIRE -> pulse completes at 5 cycles, then IDLE.
REQ-021 RESET_N pulsed low at FIRE cycle 2 -> WDT_RST_N=1 with no clock edge, flag=0; CLR_FLAG coincident with fire -> flag=1.

Source files
------------

// File: rtl/watchdog_reset_gen.sv
// Watchdog: fires a fixed-width active-low reset pulse when ENABLE is held
// and KICK shows no rising edge for TIMEOUT_CYC cycles; TIMEOUT_FLAG records every fire.
module watchdog_reset_gen #(
  parameter int unsigned TIMEOUT_CYC = 50000000,
  parameter int unsigned PULSE_CYC   = 5000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       OSC_50,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic       KICK,
  input  logic       CLR_FLAG,
  output logic       WDT_RST_N,
  output logic       TIMEOUT_FLAG,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIRE = 2'b10,
    DEAD = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic       kick_s1;
  logic       kick_s2;
  logic       kick_s3;
  logic [1:0] sync_vld;
  logic       kick_armed;
  logic       kick_edge;

  // kick_armed only rises once the synchronizer has carried a genuine low
  // sample of KICK, so a KICK already high at reset release is not a kick.
  always_ff @(posedge OSC_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      kick_s1    <= 1'b0;
      kick_s2    <= 1'b0;
      kick_s3    <= 1'b0;
      sync_vld   <= 2'b00;
      kick_armed <= 1'b0;
    end else begin
      kick_s1  <= KICK;
      kick_s2  <= kick_s1;
      kick_s3  <= kick_s2;
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && !kick_s2) begin
        kick_armed <= 1'b1;
      end
    end
  end

  assign kick_edge = kick_s2 & ~kick_s3 & kick_armed;

  always_ff @(posedge OSC_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      cnt          <= '0;
      WDT_RST_N    <= 1'b1;
      TIMEOUT_FLAG <= 1'b0;
    end else begin
      // A fire in RUN assigns the flag again below, so set beats clear.
      if (CLR_FLAG) begin
        TIMEOUT_FLAG <= 1'b0;
      end
      case (state)
        IDLE: begin
          cnt       <= '0;
          WDT_RST_N <= 1'b1;
          if (ENABLE) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (kick_edge) begin
            cnt <= '0;
          end else if (!ENABLE) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state        <= FIRE;
            cnt          <= '0;
            WDT_RST_N    <= 1'b0;
            TIMEOUT_FLAG <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        FIRE: begin
          if (cnt == PULSE_LAST) begin
            WDT_RST_N <= 1'b1;
            cnt       <= '0;
            state     <= ENABLE ? RUN : IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          WDT_RST_N <= 1'b1;
        end
      endcase
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_watchdog_reset_gen.sv
// Bench for watchdog_reset_gen: directed timing checks plus randomized traffic
// compared every cycle against an elapsed-time model of the watchdog.
`timescale 1ns/1ps
module tb_watchdog_reset_gen;

  localparam int TO = 20;
  localparam int PW = 5;

  logic       OSC_50   = 1'b0;
  logic       RESET_N  = 1'b0;
  logic       ENABLE   = 1'b0;
  logic       KICK     = 1'b0;
  logic       CLR_FLAG = 1'b0;
  logic       WDT_RST_N;
  logic       TIMEOUT_FLAG;
  logic [1:0] STATE;

  int checks   = 0;
  int failures = 0;

  watchdog_reset_gen #(
    .TIMEOUT_CYC(TO),
    .PULSE_CYC  (PW),
    .CNT_W      (32)
  ) dut (
    .OSC_50      (OSC_50),
    .RESET_N     (RESET_N),
    .ENABLE      (ENABLE),
    .KICK        (KICK),
    .CLR_FLAG    (CLR_FLAG),
    .WDT_RST_N   (WDT_RST_N),
    .TIMEOUT_FLAG(TIMEOUT_FLAG),
    .STATE       (STATE)
  );

  always #5 OSC_50 = ~OSC_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 watching, 2 pulsing (these are also the STATE codes).
  // age = cycles elapsed since the last service/clear or since the pulse began.
  int ks[$];
  bit m_armed = 1'b0;
  int m_mode  = 0;
  int m_age   = 0;
  bit m_flag  = 1'b0;
  int m_n;
  bit m_kick;
  bit m_fire;

  always @(posedge OSC_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      ks.delete();
      m_armed = 1'b0;
      m_mode  = 0;
      m_age   = 0;
      m_flag  = 1'b0;
    end else begin
      // A kick is a rising step in the KICK sample stream, seen two samples
      // late, and only once some sample after reset has been low.
      m_n = ks.size();
      if (m_n >= 3 && ks[m_n-3] == 0) m_armed = 1'b1;
      m_kick = m_armed && (ks[m_n-2] == 1) && (ks[m_n-3] == 0);
      ks.push_back(int'(KICK));
      if (ks.size() > 3) void'(ks.pop_front());

      m_fire = 1'b0;
      if (m_mode == 0) begin
        if (ENABLE) begin m_mode = 1; m_age = 0; end
      end else if (m_mode == 1) begin
        if (m_kick) m_age = 0;
        else if (!ENABLE) begin m_mode = 0; m_age = 0; end
        else if (m_age + 1 == TO) begin m_mode = 2; m_age = 0; m_fire = 1'b1; end
        else m_age++;
      end else begin
        if (m_age + 1 == PW) begin m_mode = ENABLE ? 1 : 0; m_age = 0; end
        else m_age++;
      end
      if (m_fire) m_flag = 1'b1;
      else if (CLR_FLAG) m_flag = 1'b0;
    end
  end

  always @(negedge OSC_50) begin
    chk("model_state", {30'd0, STATE}, m_mode);
    chk("model_wdt_rst_n", {31'd0, WDT_RST_N}, (m_mode == 2) ? 0 : 1);
    chk("model_flag", {31'd0, TIMEOUT_FLAG}, {31'd0, m_flag});
  end

  task automatic tick();
    @(posedge OSC_50);
    #1;
  endtask

  task automatic do_reset(input logic kick_level);
    RESET_N  = 1'b0;
    ENABLE   = 1'b0;
    CLR_FLAG = 1'b0;
    KICK     = kick_level;
    repeat (3) tick();
    RESET_N = 1'b1;
  endtask

  // Edges until WDT_RST_N reaches lvl; -1 if it never does within the bound.
  task automatic ticks_until(input logic lvl, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (WDT_RST_N !== lvl && n < 200);
    if (WDT_RST_N !== lvl) n = -1;
  endtask

  int n, n2, low_cnt, kp;

  initial begin
    // Reset values
    do_reset(1'b0);
    chk("reset_state", {30'd0, STATE}, 0);
    chk("reset_wdt", {31'd0, WDT_RST_N}, 1);
    chk("reset_flag", {31'd0, TIMEOUT_FLAG}, 0);

    // Free-running fire: 20 cycles to fire, 5 low, period 25
    ENABLE = 1'b1;
    tick();
    chk("run_entry", {30'd0, STATE}, 1);
    ticks_until(1'b0, n);
    chk("fire_delay", n, 20);
    chk("fire_state", {30'd0, STATE}, 2);
    ticks_until(1'b1, n);
    chk("pulse_width", n, 5);
    chk("flag_after_fire", {31'd0, TIMEOUT_FLAG}, 1);
    ticks_until(1'b0, n2);
    chk("fire_period", n + n2, 25);

    // Regular service keeps the watchdog quiet
    do_reset(1'b0);
    repeat (2) tick();
    ENABLE  = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      KICK = ((i % 15) < 3);
      tick();
      if (WDT_RST_N !== 1'b1) low_cnt++;
    end
    KICK = 1'b0;
    chk("serviced_low_cycles", low_cnt, 0);
    chk("serviced_flag", {31'd0, TIMEOUT_FLAG}, 0);

    // Kick arriving on the terminal count wins; counting restarts from zero
    do_reset(1'b0);
    repeat (2) tick();
    ENABLE = 1'b1;
    tick();
    repeat (17) tick();
    KICK = 1'b1;
    repeat (3) tick();
    chk("terminal_kick_state", {30'd0, STATE}, 1);
    chk("terminal_kick_wdt", {31'd0, WDT_RST_N}, 1);
    KICK = 1'b0;
    ticks_until(1'b0, n);
    chk("after_terminal_kick_delay", n, 20);
    // A kick during the pulse does not shorten it
    KICK = 1'b1;
    ticks_until(1'b1, n);
    chk("pulse_with_kick", n, 5);
    KICK = 1'b0;

    // ENABLE dropped while counting, then during the pulse
    do_reset(1'b0);
    repeat (2) tick();
    ENABLE = 1'b1;
    tick();
    repeat (10) tick();
    ENABLE = 1'b0;
    tick();
    chk("disable_state", {30'd0, STATE}, 0);
    chk("disable_wdt", {31'd0, WDT_RST_N}, 1);
    ENABLE = 1'b1;
    ticks_until(1'b0, n);
    chk("reenable_fire_delay", n, 21);
    ENABLE = 1'b0;
    ticks_until(1'b1, n);
    chk("disabled_pulse_width", n, 5);
    chk("disabled_pulse_end_state", {30'd0, STATE}, 0);
    CLR_FLAG = 1'b1;
    tick();
    CLR_FLAG = 1'b0;
    chk("clear_flag", {31'd0, TIMEOUT_FLAG}, 0);

    // Clear coincident with fire, then reset during the pulse
    do_reset(1'b0);
    repeat (2) tick();
    ENABLE = 1'b1;
    tick();
    repeat (19) tick();
    CLR_FLAG = 1'b1;
    tick();
    CLR_FLAG = 1'b0;
    chk("clear_vs_fire_flag", {31'd0, TIMEOUT_FLAG}, 1);
    chk("clear_vs_fire_wdt", {31'd0, WDT_RST_N}, 0);
    tick();
    #2;
    RESET_N = 1'b0;
    #1;
    chk("async_reset_wdt", {31'd0, WDT_RST_N}, 1);
    chk("async_reset_flag", {31'd0, TIMEOUT_FLAG}, 0);
    chk("async_reset_state", {30'd0, STATE}, 0);
    tick();
    RESET_N = 1'b1;

    // KICK high across reset release is not a kick
    do_reset(1'b1);
    ENABLE = 1'b1;
    ticks_until(1'b0, n);
    chk("held_kick_fire_delay", n, 21);
    KICK = 1'b0;
    ticks_until(1'b1, n);

    // Randomized traffic, checked by the per-cycle compare process
    do_reset(1'b0);
    kp = 8;
    for (int i = 0; i < 5000; i++) begin
      if (i % 400 == 0) begin
        case ($urandom_range(0, 3))
          0:       kp = 2;
          1:       kp = 8;
          2:       kp = 30;
          default: kp = 1000;
        endcase
      end
      ENABLE   = ($urandom_range(0, 19) != 0);
      CLR_FLAG = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, kp) == 0) KICK = ~KICK;
      if ($urandom_range(0, 599) == 0) begin
        RESET_N = 1'b0;
        KICK    = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 3)) tick();
        RESET_N = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
